iob_rr_arbiter: RTL and testbench
=================================

// Module: iob_rr_arbiter
// PURPOSE
//  Round-robin arbiter that shares a single IOb slave port among N_MASTERS IOb requesters.
//  It sits between the Wishbone-to-IOb bridge(s), the DMA side of the Ethernet MAC and the memory/peripheral IOb slave.
//  One transaction is outstanding at a time. A watchdog aborts a transaction if the slave hangs.
// PARAMETERS
//  N_MASTERS   2   number of requesters (>=2)
//  ADDR_W      32  address width
//  DATA_W      32  data width (multiple of 8)
//  TIMEOUT_CYC 255 max BUSY cycles before abort; 0 = watchdog disabled
// PORTS
//  clk_i        in   1                  clock
//  arst_i       in   1                  reset; asynchronous, active-high
//  m_valid_i    in   N_MASTERS          per-master request; held until that master's m_ready_o
//  m_address_i  in   N_MASTERS*ADDR_W   per-master address; master i at [i*ADDR_W +: ADDR_W]
//  m_wdata_i    in   N_MASTERS*DATA_W   per-master write data
//  m_wstrb_i    in   N_MASTERS*DATA_W/8 per-master byte strobes; all-zero = read
//  m_rdata_o    out  N_MASTERS*DATA_W   per-master read data
//  m_ready_o    out  N_MASTERS          per-master completion pulse
//  valid_o      out  1                  slave request
//  address_o    out  ADDR_W             slave address
//  wdata_o      out  DATA_W             slave write data
//  wstrb_o      out  DATA_W/8           slave byte strobes
//  rdata_i      in   DATA_W             slave read data
//  ready_i      in   1                  slave completion
//  grant_o      out  N_MASTERS          one-hot current owner; 0 when IDLE
//  timeout_o    out  1                  one-cycle pulse on watchdog abort
// BEHAVIOUR
//  Reset values: state=IDLE; grant_o=0; valid_o=0; address_o/wdata_o/wstrb_o=0; timeout_o=0; cnt=0;
//   last_grant=N_MASTERS-1, so master 0 wins first.
//  FSM IDLE: if any m_valid_i, pick the first requester searching upward from last_grant+1 (mod N).
//   Register grant, address, wdata and wstrb from that master; cnt<=0; go to BUSY. Otherwise stay.
//  FSM BUSY: valid_o=1; address/wdata/wstrb come from the captured registers, so master changes are ignored.
//   Slave side:
//   - ready_i=1: m_ready_o[g]=1 and m_rdata_o[g]=rdata_i, combinational in the same cycle.
//     last_grant<=g; next state IDLE; valid_o and grant_o drop the next cycle.
//   - ready_i=0: cnt++. If TIMEOUT_CYC!=0 and cnt==TIMEOUT_CYC-1, abort:
//     m_ready_o[g]=1 with m_rdata_o[g]=0, timeout_o=1, last_grant<=g, next state IDLE.
//   Master side:
//   - Granted master dropping m_valid_i mid-transaction does not cancel the transaction.
//  Non-granted masters: m_ready_o=0 and m_rdata_o slice=0 at all times.
//  ready_i in IDLE (including a late reply after an abort) is ignored; nothing is routed.
//  Latency: valid request in IDLE at cycle t -> valid_o at t+1. Slave ready at t+k -> master ready at t+k.
//   Next grant is registered at t+k+1, and that transaction's valid_o rises at t+k+2. One idle cycle between transactions.
//  Fairness: any continuously requesting master is served within N_MASTERS transactions.
//  Simultaneous ready_i and watchdog expiry: ready_i wins; normal completion, no timeout_o.
//  arst_i asserted mid-transaction: immediate return to reset values; the in-flight transaction is dropped
//   and no m_ready_o is issued.
//  cnt width: $clog2(TIMEOUT_CYC+1); cnt saturates (does not wrap) when the watchdog is disabled.
// TESTING
//  1. Single read: m_valid_i=01, addr 0x100, slave ready 3 cycles later with 0xCAFEF00D
//     -> valid_o for 3 cycles, address_o=0x100, m_ready_o=01, m_rdata_o[0]=0xCAFEF00D.
//  2. Contention: m_valid_i=11 held, slave ready in 1 cycle
//     -> grants alternate 01,10,01,10 with an idle cycle between each; m_ready_o matches grant.
//  3. Write capture: master1 writes 0x55AA to 0x20 with wstrb=0011 and changes its inputs after grant
//     -> slave sees the original values until ready_i.
//  4. Watchdog: TIMEOUT_CYC=8, slave never readies
//     -> after 8 BUSY cycles m_ready_o[g]=1, rdata=0, timeout_o pulses once.
//     A late ready_i in IDLE causes no m_ready_o.
//  5. Collision: ready_i arrives on the expiry cycle -> normal completion, timeout_o=0.
//  6. Reset: arst_i raised in BUSY -> outputs 0 asynchronously. After release, with m_valid_i=11,
//     master 0 is granted first.

Source files
------------

// File: rtl/iob_rr_arbiter.sv
// Round-robin arbiter sharing one IOb slave port among N_MASTERS IOb requesters.
// One transaction is outstanding at a time; a watchdog aborts transactions the slave never completes.
module iob_rr_arbiter #(
  parameter int N_MASTERS   = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                          clk_i,
  input  logic                          arst_i,
  input  logic [N_MASTERS-1:0]          m_valid_i,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_address_i,
  input  logic [N_MASTERS*DATA_W-1:0]   m_wdata_i,
  input  logic [N_MASTERS*DATA_W/8-1:0] m_wstrb_i,
  output logic [N_MASTERS*DATA_W-1:0]   m_rdata_o,
  output logic [N_MASTERS-1:0]          m_ready_o,
  output logic                          valid_o,
  output logic [ADDR_W-1:0]             address_o,
  output logic [DATA_W-1:0]             wdata_o,
  output logic [DATA_W/8-1:0]           wstrb_o,
  input  logic [DATA_W-1:0]             rdata_i,
  input  logic                          ready_i,
  output logic [N_MASTERS-1:0]          grant_o,
  output logic                          timeout_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = $clog2(N_MASTERS);
  localparam int CNT_W  = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYC == 0) ? '0 : CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic WDOG_EN = (TIMEOUT_CYC != 0);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state;
  logic [IDX_W-1:0]   last_grant;
  logic [IDX_W-1:0]   owner;
  logic [CNT_W-1:0]   cnt;

  logic               any_req;
  logic [IDX_W-1:0]   pick;
  logic [IDX_W:0]     sum;
  logic [IDX_W-1:0]   cand;
  logic [N_MASTERS-1:0] pick_onehot;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic [STRB_W-1:0]  sel_wstrb;
  logic               done;
  logic               abort;

  // Search upward from the master after the last owner, wrapping modulo N_MASTERS.
  always_comb begin
    any_req     = 1'b0;
    pick        = last_grant;
    sum         = '0;
    cand        = '0;
    pick_onehot = '0;
    sel_addr    = '0;
    sel_wdata   = '0;
    sel_wstrb   = '0;
    for (int k = 1; k <= N_MASTERS; k++) begin
      sum = {1'b0, last_grant} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(N_MASTERS))
        sum = sum - (IDX_W+1)'(N_MASTERS);
      cand = sum[IDX_W-1:0];
      if (!any_req && m_valid_i[cand]) begin
        any_req = 1'b1;
        pick    = cand;
      end
    end
    for (int i = 0; i < N_MASTERS; i++) begin
      if (IDX_W'(i) == pick) begin
        pick_onehot[i] = 1'b1;
        sel_addr       = m_address_i[i*ADDR_W +: ADDR_W];
        sel_wdata      = m_wdata_i[i*DATA_W +: DATA_W];
        sel_wstrb      = m_wstrb_i[i*STRB_W +: STRB_W];
      end
    end
  end

  // A slave reply on the expiry cycle counts as a normal completion.
  assign done      = (state == BUSY) && ready_i;
  assign abort     = (state == BUSY) && !ready_i && WDOG_EN && (cnt == CNT_LAST);
  assign timeout_o = abort;

  always_comb begin
    m_ready_o = '0;
    m_rdata_o = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (IDX_W'(i) == owner) begin
        m_ready_o[i] = done | abort;
        if (done)
          m_rdata_o[i*DATA_W +: DATA_W] = rdata_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state      <= IDLE;
      last_grant <= IDX_W'(N_MASTERS - 1);
      owner      <= '0;
      cnt        <= '0;
      grant_o    <= '0;
      valid_o    <= 1'b0;
      address_o  <= '0;
      wdata_o    <= '0;
      wstrb_o    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state     <= BUSY;
            owner     <= pick;
            grant_o   <= pick_onehot;
            valid_o   <= 1'b1;
            address_o <= sel_addr;
            wdata_o   <= sel_wdata;
            wstrb_o   <= sel_wstrb;
            cnt       <= '0;
          end
        end
        BUSY: begin
          if (done || abort) begin
            state      <= IDLE;
            last_grant <= owner;
            grant_o    <= '0;
            valid_o    <= 1'b0;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iob_rr_arbiter.sv
// Self-checking bench for iob_rr_arbiter: directed vector table, hand-written corner
// sequences, and randomized transactions checked against a round-robin reference model.
module tb_iob_rr_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int T  = 8;

  logic            clk;
  logic            arst;
  logic [N-1:0]    m_valid;
  logic [N*AW-1:0] m_address;
  logic [N*DW-1:0] m_wdata;
  logic [N*DW/8-1:0] m_wstrb;
  logic [N*DW-1:0] m_rdata;
  logic [N-1:0]    m_ready;
  logic            valid;
  logic [AW-1:0]   address;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic [DW-1:0]   rdata;
  logic            ready;
  logic [N-1:0]    grant;
  logic            timeout;

  int checks = 0;
  int errors = 0;
  int last_served = N - 1;

  logic [AW-1:0]   addr_q [N];
  logic [DW-1:0]   wd_q   [N];
  logic [DW/8-1:0] ws_q   [N];

  typedef struct {
    logic [N-1:0] req;
    int           lat;
    logic [31:0]  rd;
    logic [31:0]  a0;
    logic [31:0]  a1;
    logic [31:0]  wd1;
    logic [3:0]   ws1;
    int           exp_w;
    logic         exp_to;
  } vec_t;

  vec_t vecs [9];

  iob_rr_arbiter #(
    .N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(T)
  ) dut (
    .clk_i(clk), .arst_i(arst),
    .m_valid_i(m_valid), .m_address_i(m_address), .m_wdata_i(m_wdata), .m_wstrb_i(m_wstrb),
    .m_rdata_o(m_rdata), .m_ready_o(m_ready),
    .valid_o(valid), .address_o(address), .wdata_o(wdata), .wstrb_o(wstrb),
    .rdata_i(rdata), .ready_i(ready),
    .grant_o(grant), .timeout_o(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL global_time_limit got running expected finished");
    $fatal(1, "[TB] simulation time limit");
  end

  task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [N-1:0] req);
    m_valid = req;
    for (int i = 0; i < N; i++) begin
      m_address[i*AW +: AW]     = addr_q[i];
      m_wdata[i*DW +: DW]       = wd_q[i];
      m_wstrb[i*DW/8 +: DW/8]   = ws_q[i];
    end
  endtask

  // Reference round-robin choice: first requester after the last one served.
  function automatic int model_winner(input logic [N-1:0] req);
    int w;
    w = -1;
    for (int k = 1; k <= N; k++)
      if (w < 0 && req[(last_served + k) % N]) w = (last_served + k) % N;
    return w;
  endfunction

  task automatic scramble_inputs();
    for (int i = 0; i < N; i++) begin
      addr_q[i] = $urandom;
      wd_q[i]   = $urandom;
      ws_q[i]   = 4'($urandom_range(0, 15));
    end
    apply_stimulus(2'($urandom_range(0, 3)));
  endtask

  // One transaction: idle cycle with request, then BUSY cycles until reply (lat) or abort.
  // lat = 0 means the slave never replies.
  task automatic run_txn(input logic [N-1:0] req, input int lat, input logic [31:0] rd,
                         input int exp_w, input logic exp_to);
    logic [AW-1:0]   ea;
    logic [DW-1:0]   ew;
    logic [DW/8-1:0] es;
    logic [N*DW-1:0] exp_rd;
    logic [N-1:0]    exp_g;
    bit              finished;
    ea = addr_q[exp_w];
    ew = wd_q[exp_w];
    es = ws_q[exp_w];
    exp_g = '0;
    exp_g[exp_w] = 1'b1;
    exp_rd = '0;
    exp_rd[exp_w*DW +: DW] = rd;
    finished = 0;

    @(negedge clk);
    ready = 1'b0;
    rdata = rd;
    apply_stimulus(req);
    #1;
    check_output("idle_valid", 64'(valid), 64'd0);
    check_output("idle_grant", 64'(grant), 64'd0);
    check_output("idle_m_ready", 64'(m_ready), 64'd0);

    for (int b = 1; b <= T; b++) begin
      @(negedge clk);
      scramble_inputs();
      ready = (b == lat);
      #1;
      check_output("busy_valid", 64'(valid), 64'd1);
      check_output("busy_grant", 64'(grant), 64'(exp_g));
      check_output("busy_address", 64'(address), 64'(ea));
      check_output("busy_wdata", 64'(wdata), 64'(ew));
      check_output("busy_wstrb", 64'(wstrb), 64'(es));
      if (b == lat) begin
        check_output("done_m_ready", 64'(m_ready), 64'(exp_g));
        check_output("done_m_rdata", 64'(m_rdata), 64'(exp_rd));
        check_output("done_timeout", 64'(timeout), 64'(exp_to));
        finished = 1;
        break;
      end else if (b == T) begin
        check_output("abort_m_ready", 64'(m_ready), 64'(exp_g));
        check_output("abort_m_rdata", 64'(m_rdata), 64'd0);
        check_output("abort_timeout", 64'(timeout), 64'(exp_to));
        finished = 1;
      end else begin
        check_output("wait_m_ready", 64'(m_ready), 64'd0);
        check_output("wait_timeout", 64'(timeout), 64'd0);
      end
    end
    if (!finished) check_output("txn_finished", 64'd0, 64'd1);
    last_served = exp_w;
  endtask

  initial begin
    arst = 1'b1;
    ready = 1'b0;
    rdata = '0;
    for (int i = 0; i < N; i++) begin
      addr_q[i] = '0; wd_q[i] = '0; ws_q[i] = '0;
    end
    apply_stimulus('0);

    vecs[0] = '{2'b01, 3, 32'hCAFEF00D, 32'h100, 32'h200, 32'h0,    4'b0000, 0, 1'b0};
    vecs[1] = '{2'b11, 1, 32'h11111111, 32'h104, 32'h204, 32'h0,    4'b0000, 1, 1'b0};
    vecs[2] = '{2'b11, 1, 32'h22222222, 32'h108, 32'h208, 32'h0,    4'b0000, 0, 1'b0};
    vecs[3] = '{2'b11, 1, 32'h33333333, 32'h10C, 32'h20C, 32'h0,    4'b0000, 1, 1'b0};
    vecs[4] = '{2'b11, 1, 32'h44444444, 32'h110, 32'h210, 32'h0,    4'b0000, 0, 1'b0};
    vecs[5] = '{2'b10, 4, 32'h0,        32'h114, 32'h20,  32'h55AA, 4'b0011, 1, 1'b0};
    vecs[6] = '{2'b10, 0, 32'hDEADBEEF, 32'h118, 32'h218, 32'h0,    4'b0000, 1, 1'b1};
    vecs[7] = '{2'b11, 8, 32'h12345678, 32'h11C, 32'h21C, 32'h0,    4'b0000, 0, 1'b0};
    vecs[8] = '{2'b11, 9, 32'h87654321, 32'h120, 32'h220, 32'h0,    4'b0000, 1, 1'b1};

    #1;
    check_output("reset_valid", 64'(valid), 64'd0);
    check_output("reset_grant", 64'(grant), 64'd0);
    check_output("reset_address", 64'(address), 64'd0);
    check_output("reset_timeout", 64'(timeout), 64'd0);
    check_output("reset_m_ready", 64'(m_ready), 64'd0);
    @(negedge clk);
    @(negedge clk);
    arst = 1'b0;

    for (int v = 0; v < 9; v++) begin
      addr_q[0] = vecs[v].a0;  wd_q[0] = $urandom; ws_q[0] = 4'b0000;
      addr_q[1] = vecs[v].a1;  wd_q[1] = vecs[v].wd1; ws_q[1] = vecs[v].ws1;
      run_txn(vecs[v].req, vecs[v].lat, vecs[v].rd, vecs[v].exp_w, vecs[v].exp_to);
    end

    // Late slave reply while idle after an abort must not reach any master.
    @(negedge clk);
    apply_stimulus('0);
    ready = 1'b1;
    rdata = 32'hBADC0DE5;
    #1;
    check_output("late_ready_m_ready", 64'(m_ready), 64'd0);
    check_output("late_ready_m_rdata", 64'(m_rdata), 64'd0);
    check_output("late_ready_valid", 64'(valid), 64'd0);
    @(negedge clk);
    ready = 1'b0;
    #1;
    check_output("late_ready_still_idle", 64'(valid), 64'd0);

    // Reset in the middle of a transaction drops it immediately.
    @(negedge clk);
    addr_q[0] = 32'h300; addr_q[1] = 32'h400;
    apply_stimulus(2'b11);
    @(negedge clk);
    #1;
    check_output("pre_reset_busy", 64'(valid), 64'd1);
    ready = 1'b1;
    arst  = 1'b1;
    #1;
    check_output("arst_valid", 64'(valid), 64'd0);
    check_output("arst_grant", 64'(grant), 64'd0);
    check_output("arst_address", 64'(address), 64'd0);
    check_output("arst_wdata", 64'(wdata), 64'd0);
    check_output("arst_m_ready", 64'(m_ready), 64'd0);
    check_output("arst_timeout", 64'(timeout), 64'd0);
    @(negedge clk);
    arst  = 1'b0;
    ready = 1'b0;
    apply_stimulus('0);
    last_served = N - 1;
    addr_q[0] = 32'h500; addr_q[1] = 32'h600;
    run_txn(2'b11, 2, 32'h0BADF00D, 0, 1'b0);

    // Randomized traffic against the round-robin model.
    for (int r = 0; r < 60; r++) begin
      logic [N-1:0] req;
      int           lat;
      logic [31:0]  rd;
      req = 2'($urandom_range(1, 3));
      lat = $urandom_range(0, 10);
      rd  = $urandom;
      for (int i = 0; i < N; i++) begin
        addr_q[i] = $urandom; wd_q[i] = $urandom; ws_q[i] = 4'($urandom_range(0, 15));
      end
      run_txn(req, lat, rd, model_winner(req), (lat == 0) || (lat > T));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
